alu_cmd_issuer: RTL and testbench

Command-side front end for the `alu_32bit` datapath. It accepts tagged operation commands over a valid/ready interface and buffers them in a small FIFO. It issues one command per cycle to the combinational ALU through registered operand/opcode outputs, then captures the result and flags into a valid/ready response register. It is the initiator side of the ALU operand/opcode/result interface, driving exactly the port set the ALU exposes (A, B, opcode in; result, zero, carry_out, overflow out).

---
 rtl/alu_cmd_issuer.sv | 144 ++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - tagged command FIFO, registered ALU issue stage and response register
// Define ALU_ISSUER_ACC_EN to add the accumulator operand path (cmd_acc selects acc as A).
module alu_cmd_issuer #(
   parameter int FIFO_DEPTH = 4,
   parameter int TAG_W      = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [31:0]                   cmd_a,
   input  logic [31:0]                   cmd_b,
   input  logic [2:0]                    cmd_op,
   input  logic                          cmd_acc,
   input  logic [TAG_W-1:0]              cmd_tag,
   output logic [31:0]                   alu_a,
   output logic [31:0]                   alu_b,
   output logic [2:0]                    alu_opcode,
   input  logic [31:0]                   alu_result,
   input  logic                          alu_zero,
   input  logic                          alu_carry_out,
   input  logic                          alu_overflow,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [31:0]                   rsp_result,
   output logic                          rsp_zero,
   output logic                          rsp_carry,
   output logic                          rsp_overflow,
   output logic [TAG_W-1:0]              rsp_tag,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          busy
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]      mem_a   [FIFO_DEPTH];
   logic [31:0]      mem_b   [FIFO_DEPTH];
   logic [2:0]       mem_op  [FIFO_DEPTH];
   logic [TAG_W-1:0] mem_tag [FIFO_DEPTH];

   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [CW-1:0]    count;
   logic             x_valid;
   logic [TAG_W-1:0] x_tag;
   logic             push;
   logic             pop;
   logic             x_adv;
   logic [31:0]      head_a;

   assign cmd_ready  = !rst && (count < CW'(FIFO_DEPTH));
   assign push       = cmd_valid && cmd_ready;
   assign x_adv      = x_valid && (!rsp_valid || rsp_ready);
   // no bypass: a command must sit in the FIFO for at least one edge
   assign pop        = (count != '0) && (!x_valid || x_adv);
   assign fifo_count = count;
   assign busy       = (count != '0) || x_valid || rsp_valid;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wptr]   <= cmd_a;
         mem_b[wptr]   <= cmd_b;
         mem_op[wptr]  <= cmd_op;
         mem_tag[wptr] <= cmd_tag;
      end
   end

`ifdef ALU_ISSUER_ACC_EN
   logic [31:0] acc;
   logic        mem_acc [FIFO_DEPTH];

   always_ff @(posedge clk) begin
      if (push) begin
         mem_acc[wptr] <= cmd_acc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
      end else if (x_adv) begin
         acc <= alu_result;
      end
   end

   // acc is only updated at this same edge, so forward the result being captured
   assign head_a = mem_acc[rptr] ? (x_adv ? alu_result : acc) : mem_a[rptr];
`else
   logic unused_cmd_acc;
   assign unused_cmd_acc = cmd_acc;
   assign head_a         = mem_a[rptr];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr         <= '0;
         rptr         <= '0;
         count        <= '0;
         x_valid      <= 1'b0;
         x_tag        <= '0;
         alu_a        <= '0;
         alu_b        <= '0;
         alu_opcode   <= '0;
         rsp_valid    <= 1'b0;
         rsp_result   <= '0;
         rsp_zero     <= 1'b0;
         rsp_carry    <= 1'b0;
         rsp_overflow <= 1'b0;
         rsp_tag      <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + 1'b1;
         end

         if (pop) begin
            rptr       <= rptr + 1'b1;
            alu_a      <= head_a;
            alu_b      <= mem_b[rptr];
            alu_opcode <= mem_op[rptr];
            x_tag      <= mem_tag[rptr];
            x_valid    <= 1'b1;
         end else if (x_adv) begin
            x_valid <= 1'b0;
         end

         if (x_adv) begin
            rsp_valid    <= 1'b1;
            rsp_result   <= alu_result;
            rsp_zero     <= alu_zero;
            rsp_carry    <= alu_carry_out;
            rsp_overflow <= alu_overflow;
            rsp_tag      <= x_tag;
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end

         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - self-checking bench for alu_cmd_issuer with a behavioural ALU
// Reference model predicts each response in command order; define ALU_ISSUER_ACC_EN to cover acc.
module tb_alu_cmd_issuer;
   localparam int TAG_W = 4;

   typedef struct packed {
      logic [31:0]      result;
      logic             zero;
      logic             carry;
      logic             overflow;
      logic [TAG_W-1:0] tag;
   } rsp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [31:0]      cmd_a;
   logic [31:0]      cmd_b;
   logic [2:0]       cmd_op;
   logic             cmd_acc;
   logic [TAG_W-1:0] cmd_tag;
   logic [31:0]      alu_a;
   logic [31:0]      alu_b;
   logic [2:0]       alu_opcode;
   logic [31:0]      alu_result;
   logic             alu_zero;
   logic             alu_carry_out;
   logic             alu_overflow;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [31:0]      rsp_result;
   logic             rsp_zero;
   logic             rsp_carry;
   logic             rsp_overflow;
   logic [TAG_W-1:0] rsp_tag;
   logic [2:0]       fifo_count;
   logic             busy;

   int   n_checks = 0;
   int   n_fail   = 0;
   rsp_t exp_q[$];
   rsp_t got_q[$];
   logic [31:0] last_res = 32'd0;

   always #5 clk = ~clk;

   alu_cmd_issuer #(.FIFO_DEPTH(4), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .cmd_op(cmd_op), .cmd_acc(cmd_acc), .cmd_tag(cmd_tag),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry_out(alu_carry_out),
      .alu_overflow(alu_overflow),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow),
      .rsp_tag(rsp_tag), .fifo_count(fifo_count), .busy(busy)
   );

   function automatic rsp_t alu_fn(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] op, input logic [TAG_W-1:0] tag);
      rsp_t        s;
      logic [32:0] w;
      s     = '0;
      s.tag = tag;
      case (op)
         3'b000: begin
            w = {1'b0, a} + {1'b0, b};
            s.result = w[31:0]; s.carry = w[32];
            s.overflow = (a[31] == b[31]) && (s.result[31] != a[31]);
         end
         3'b001: begin
            w = {1'b0, a} + {1'b0, ~b} + 33'd1;
            s.result = w[31:0]; s.carry = w[32];
            s.overflow = (a[31] != b[31]) && (s.result[31] != a[31]);
         end
         3'b010:  s.result = a & b;
         3'b011:  s.result = a | b;
         3'b100:  s.result = a ^ b;
         3'b101:  s.result = ~(a & b);
         3'b110:  s.result = ~a;
         default: s.result = a;
      endcase
      s.zero = (s.result == 32'd0);
      return s;
   endfunction

   // behavioural combinational ALU on the issue side
   rsp_t stub;
   assign stub          = alu_fn(alu_a, alu_b, alu_opcode, '0);
   assign alu_result    = stub.result;
   assign alu_zero      = stub.zero;
   assign alu_carry_out = stub.carry;
   assign alu_overflow  = stub.overflow;

   logic [110:0] all_out;
   assign all_out = {alu_a, alu_b, alu_opcode, rsp_valid, rsp_result, rsp_zero, rsp_carry,
                     rsp_overflow, rsp_tag, fifo_count, busy};
   logic [106:0] stall_view;
   assign stall_view = {rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_overflow, rsp_tag,
                        alu_a, alu_b, alu_opcode};

   // called at a negedge with inputs set; records handshakes, advances one clock
   task automatic tick();
      rsp_t        e;
      logic [31:0] a_eff;
      if (cmd_valid && cmd_ready) begin
         a_eff = cmd_a;
`ifdef ALU_ISSUER_ACC_EN
         if (cmd_acc) a_eff = last_res;
`endif
         e = alu_fn(a_eff, cmd_b, cmd_op, cmd_tag);
         last_res = e.result;
         exp_q.push_back(e);
      end
      if (rsp_valid && rsp_ready)
         got_q.push_back({rsp_result, rsp_zero, rsp_carry, rsp_overflow, rsp_tag});
      @(posedge clk);
      @(negedge clk);
      if (rst) begin
         exp_q.delete();
         got_q.delete();
         last_res = 32'd0;
      end
   endtask

   task automatic rand_cmd();
      cmd_a   = $urandom;
      cmd_b   = ($urandom_range(0, 3) == 0) ? cmd_a : $urandom;
      cmd_op  = 3'($urandom_range(0, 7));
      cmd_tag = TAG_W'($urandom);
      cmd_acc = 1'($urandom_range(0, 1));
   endtask

   task automatic set_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag, input logic acc);
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_acc = acc;
   endtask

   task automatic drain(output bit ok);
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 40 && busy; i++) tick();
      ok = !busy;
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd_valid = 1'b1; rand_cmd();
      tick(); tick();
      n_checks++;
      if (all_out !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_out);
      end
      n_checks++;
      if (cmd_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_cmd_ready_low: got %b expected 0", cmd_ready);
      end
      rst = 1'b0; cmd_valid = 1'b0;
      tick();
      n_checks++;
      if (cmd_ready !== 1'b1 || fifo_count !== 3'd0) begin
         n_fail++; $display("FAIL reset_release: got ready %b count %0d expected 1 0", cmd_ready, fifo_count);
      end
   endtask

   task automatic test_basic();
      bit ok;
      rsp_ready = 1'b1;
      set_cmd(3'b000, 32'd5, 32'd3, 4'd1, 1'b0);
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_latency_early[%0d]: got rsp_valid %b expected 0", i, rsp_valid);
         end
         tick();
      end
      n_checks++;
      if ({rsp_valid, rsp_result, rsp_zero, rsp_tag} !== {1'b1, 32'h8, 1'b0, 4'd1}) begin
         n_fail++; $display("FAIL basic_add: got v%b %h z%b t%0d expected v1 00000008 z0 t1",
                            rsp_valid, rsp_result, rsp_zero, rsp_tag);
      end
      drain(ok);
      n_checks++;
      if (!ok || got_q.size() != 1 || exp_q.size() != 1) begin
         n_fail++; $display("FAIL basic_drain: got %0d responses expected 1", got_q.size());
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_back_to_back();
      bit ok;
      rsp_ready = 1'b1;
      set_cmd(3'b001, 32'd5, 32'd7, 4'd2, 1'b0);
      tick();
      set_cmd(3'b010, 32'hF0F0F0F0, 32'h0FF00FF0, 4'd3, 1'b0);
      tick();
      cmd_valid = 1'b0;
      tick();
      n_checks++;
      if ({rsp_valid, rsp_result, rsp_tag} !== {1'b1, 32'hFFFFFFFE, 4'd2}) begin
         n_fail++; $display("FAIL b2b_sub: got v%b %h t%0d expected v1 fffffffe t2", rsp_valid, rsp_result, rsp_tag);
      end
      tick();
      n_checks++;
      if ({rsp_valid, rsp_result, rsp_tag} !== {1'b1, 32'h00F000F0, 4'd3}) begin
         n_fail++; $display("FAIL b2b_and: got v%b %h t%0d expected v1 00f000f0 t3", rsp_valid, rsp_result, rsp_tag);
      end
      drain(ok);
      n_checks++;
      if (!ok || got_q.size() != 2) begin
         n_fail++; $display("FAIL b2b_drain: got %0d responses expected 2", got_q.size());
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_fill();
      bit ok;
      int accepted;
      accepted  = 0;
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (!cmd_ready) break;
         rand_cmd();
         accepted++;
         tick();
      end
      n_checks++;
      if (accepted != 6 || fifo_count !== 3'd4 || cmd_ready !== 1'b0) begin
         n_fail++; $display("FAIL fill_full: got accepted %0d count %0d ready %b expected 6 4 0",
                            accepted, fifo_count, cmd_ready);
      end
      rand_cmd();
      tick();
      n_checks++;
      if (fifo_count !== 3'd4 || exp_q.size() != 6) begin
         n_fail++; $display("FAIL fill_blocked: got count %0d pushes %0d expected 4 6", fifo_count, exp_q.size());
      end
      drain(ok);
      n_checks++;
      if (!ok) begin
         n_fail++; $display("FAIL fill_drain_timeout: got busy %b expected 0", busy);
      end
      n_checks++;
      if (got_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL fill_count: got %0d responses expected %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL fill_rsp[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
         end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_stall();
      bit ok;
      logic [106:0] snap;
      rsp_ready = 1'b1;
      cmd_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rand_cmd();
         tick();
      end
      n_checks++;
      if (rsp_valid !== 1'b1) begin
         n_fail++; $display("FAIL stall_rsp_present: got %b expected 1", rsp_valid);
      end
      snap      = stall_view;
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rand_cmd();
         tick();
         n_checks++;
         if (stall_view !== snap) begin
            n_fail++; $display("FAIL stall_stable[%0d]: got %h expected %h", i, stall_view, snap);
         end
      end
      drain(ok);
      n_checks++;
      if (!ok || got_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL stall_count: got %0d responses expected %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL stall_rsp[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
         end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_reset_midflight();
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_cmd();
         tick();
      end
      cmd_valid = 1'b0;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL midrst_busy_before: got %b expected 1", busy);
      end
      rst = 1'b1;
      tick();
      n_checks++;
      if (all_out !== '0 || cmd_ready !== 1'b0) begin
         n_fail++; $display("FAIL midrst_outputs: got %h ready %b expected 0 0", all_out, cmd_ready);
      end
      rst = 1'b0;
      tick();
      n_checks++;
      if (cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL midrst_ready_after: got %b expected 1", cmd_ready);
      end
      rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      n_checks++;
      if (got_q.size() != 0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL midrst_stale: got %0d responses busy %b expected 0 0", got_q.size(), busy);
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_random();
      bit ok;
      for (int i = 0; i < 300; i++) begin
         cmd_valid = ($urandom_range(0, 3) != 0);
         rand_cmd();
         rsp_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      drain(ok);
      n_checks++;
      if (!ok || got_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL random_count: got %0d responses expected %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL random_rsp[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
         end
      end
      got_q.delete(); exp_q.delete();
   endtask

`ifdef ALU_ISSUER_ACC_EN
   task automatic test_acc();
      bit ok;
      rsp_ready = 1'b1;
      set_cmd(3'b111, 32'h12345678, $urandom, 4'd5, 1'b0);
      tick();
      set_cmd(3'b000, 32'hDEADBEEF, 32'd1, 4'd6, 1'b1);
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      n_checks++;
      if ({rsp_valid, rsp_result, rsp_tag} !== {1'b1, 32'h12345679, 4'd6}) begin
         n_fail++; $display("FAIL acc_forward: got v%b %h t%0d expected v1 12345679 t6", rsp_valid, rsp_result, rsp_tag);
      end
      drain(ok);
      n_checks++;
      if (!ok || got_q.size() != 2 || exp_q.size() != 2 || got_q[1] !== exp_q[1]) begin
         n_fail++; $display("FAIL acc_drain: got %0d responses expected 2", got_q.size());
      end
      got_q.delete(); exp_q.delete();
   endtask
`endif

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
      cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_acc = 1'b0; cmd_tag = '0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_back_to_back();
      test_fill();
      test_stall();
      test_reset_midflight();
      test_random();
`ifdef ALU_ISSUER_ACC_EN
      test_acc();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
